// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fifo_wr_arbiter
// Round-robin, burst-bounded arbiter sharing one async-FIFO write port (wclk).
// Rev    : 1.0
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = 2
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_wenable,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic                      fifo_winc,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic [15:0]               xfer_cnt
);

  localparam int                c_beat_w    = $clog2(MAX_BURST) + 1;
  localparam logic [c_beat_w-1:0] c_beat_last = c_beat_w'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]   c_gnt_init  = ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ID_W-1:0]      r_grant_id;
  logic [ID_W-1:0]      r_last_gnt;
  logic [c_beat_w-1:0]  r_beat_cnt;
  logic [15:0]          r_xfer_cnt;
  logic [ID_W-1:0]      w_sel_id;
  logic [ID_W-1:0]      w_scan_idx;
  logic                 w_sel_found;
  logic                 w_gnt_valid;
  logic                 w_gnt_last;
  logic                 w_winc;
  logic                 w_burst_end;
  logic [DATA_W-1:0]    w_slice [NUM_REQ];

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_slice[g] = req_data[g*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan starts one past the last grant so every requester gets a turn.
  always_comb begin
    w_sel_id    = r_last_gnt;
    w_sel_found = 1'b0;
    w_scan_idx  = r_last_gnt;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan_idx = ID_W'((int'(r_last_gnt) + k) % NUM_REQ);
      if (!w_sel_found && req_valid[w_scan_idx]) begin
        w_sel_id    = w_scan_idx;
        w_sel_found = 1'b1;
      end
    end
  end

  assign w_gnt_valid = req_valid[r_grant_id];
  assign w_gnt_last  = req_last[r_grant_id];
  assign w_winc      = (r_state == ST_BURST) && w_gnt_valid && fifo_wenable;
  assign w_burst_end = w_winc && (w_gnt_last || (r_beat_cnt == c_beat_last));

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_found) begin
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        req_ready[r_grant_id] = fifo_wenable;
        if (w_burst_end) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_winc  = w_winc;
    fifo_wdata = '0;
    if (w_winc) begin
      fifo_wdata = w_slice[r_grant_id];
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_grant_id <= '0;
      r_last_gnt <= c_gnt_init;
      r_beat_cnt <= '0;
      r_xfer_cnt <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_sel_found) begin
        r_grant_id <= w_sel_id;
        r_beat_cnt <= '0;
      end
      if (w_winc) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
      if (w_burst_end) begin
        r_last_gnt <= r_grant_id;
      end
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state == ST_BURST);
  assign xfer_cnt = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// Bench for fifo_wr_arbiter: per-cycle reference model plus directed packet scenarios.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;

  logic              wclk         = 1'b0;
  logic              wrst_n       = 1'b0;
  logic [NREQ-1:0]   req_valid    = '0;
  logic [NREQ-1:0]   req_last     = '0;
  logic [NREQ*DW-1:0] req_data    = '0;
  logic              fifo_wenable = 1'b1;
  logic [NREQ-1:0]   req_ready;
  logic [DW-1:0]     fifo_wdata;
  logic              fifo_winc;
  logic [1:0]        grant_id;
  logic              busy;
  logic [15:0]       xfer_cnt;

  logic [1:0]  v2 = '0;
  logic [1:0]  l2 = '0;
  logic [15:0] d2 = 16'h5AA5;
  logic        e2 = 1'b1;
  logic [1:0]  r2;
  logic [7:0]  wd2;
  logic        wi2;
  logic [0:0]  gid2;
  logic        busy2;
  logic [15:0] x2;

  fifo_wr_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .MAX_BURST(MB), .ID_W(2)) u_dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_wenable(fifo_wenable),
    .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc), .grant_id(grant_id),
    .busy(busy), .xfer_cnt(xfer_cnt)
  );

  // Long bursts keep the 16-bit wrap run short.
  fifo_wr_arbiter #(.NUM_REQ(2), .DATA_W(8), .MAX_BURST(64), .ID_W(1)) u_dut_wrap (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(v2), .req_last(l2),
    .req_data(d2), .req_ready(r2), .fifo_wenable(e2),
    .fifo_wdata(wd2), .fifo_winc(wi2), .grant_id(gid2),
    .busy(busy2), .xfer_cnt(x2)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [8:0]      pq [NREQ][$];
  logic [NREQ-1:0] acc_q     = '0;
  logic            prev_busy = 1'b0;
  logic [7:0]      wlog [$];
  int              wcyc [$];
  int              glog [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: grant state tracked as plain integers.
  int m_busy  = 0;
  int m_grant = 0;
  int m_last  = NREQ - 1;
  int m_beats = 0;
  int m_xfer  = 0;

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic exp_winc_f();
    return (m_busy != 0) && req_valid[m_grant] && fifo_wenable;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready_f();
    logic [NREQ-1:0] r;
    r = '0;
    if ((m_busy != 0) && fifo_wenable) r[m_grant] = 1'b1;
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_wdata_f();
    if (exp_winc_f()) return req_data[m_grant*DW +: DW];
    return '0;
  endfunction

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_busy  <= 0;
      m_grant <= 0;
      m_last  <= NREQ - 1;
      m_beats <= 0;
      m_xfer  <= 0;
    end else if (m_busy != 0) begin
      if (exp_winc_f()) begin
        m_xfer  <= (m_xfer + 1) % 65536;
        m_beats <= m_beats + 1;
        if (req_last[m_grant] || (m_beats + 1 == MB)) begin
          m_busy <= 0;
          m_last <= m_grant;
        end
      end
    end else if (rr_pick(m_last, req_valid) >= 0) begin
      m_busy  <= 1;
      m_grant <= rr_pick(m_last, req_valid);
      m_beats <= 0;
    end
  end

  always @(negedge wclk) begin
    cyc       <= cyc + 1;
    acc_q     <= req_valid & req_ready;
    prev_busy <= busy;
    chk("ready", 32'(req_ready), 32'(exp_ready_f()));
    chk("winc", 32'(fifo_winc), 32'(exp_winc_f()));
    chk("wdata", 32'(fifo_wdata), 32'(exp_wdata_f()));
    chk("grant_id", 32'(grant_id), 32'(m_grant));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_xfer));
    if (fifo_winc) begin
      wlog.push_back(fifo_wdata);
      wcyc.push_back(cyc);
    end
    if (busy && !prev_busy) glog.push_back(int'(grant_id));
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (pq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = pq[i][0][7:0];
        req_last[i]          = pq[i][0][8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_q[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    end
    drive();
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic last);
    pq[r].push_back({last, d});
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) pq[i].delete();
    wlog.delete();
    wcyc.delete();
    glog.delete();
  endtask

  task automatic do_reset();
    wrst_n       = 1'b0;
    fifo_wenable = 1'b1;
    clear_all();
    drive();
    step();
    step();
    wrst_n = 1'b1;
    clear_all();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int b;
    b = 0;
    while (wlog.size() < n && b < budget) begin
      step();
      b++;
    end
    chk({name, "_done"}, 32'(wlog.size() >= n), 32'd1);
  endtask

  task automatic chk_wlog(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, 32'(wlog.size()), 32'(exp.size()));
    foreach (exp[k]) begin
      chk($sformatf("%s_beat%0d", name, k),
          (k < wlog.size()) ? 32'(wlog[k]) : 32'hFFFF_FFFF, 32'(exp[k]));
    end
  endtask

  task automatic chk_glog(input string name, input int exp[$]);
    foreach (exp[k]) begin
      chk($sformatf("%s_grant%0d", name, k),
          (k < glog.size()) ? 32'(glog[k]) : 32'hFFFF_FFFF, 32'(exp[k]));
    end
  endtask

  initial begin
    logic [7:0] ew[$];
    int         eg[$];
    logic       ok;

    // Single requester, held in reset with valid already high
    wrst_n = 1'b0;
    load(0, 8'h11, 1'b0); load(0, 8'h22, 1'b0); load(0, 8'h33, 1'b1);
    drive();
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_winc", 32'(fifo_winc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_xfer", 32'(xfer_cnt), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_wdata", 32'(fifo_wdata), 32'd0);
    wrst_n = 1'b1;
    wlog.delete(); wcyc.delete(); glog.delete();
    run_until(3, 20, "t1");
    step();
    step();
    ew = '{8'h11, 8'h22, 8'h33};
    chk_wlog("t1", ew);
    chk("t1_consecutive", (wcyc.size() == 3) ? 32'(wcyc[2] - wcyc[0]) : 32'hFFFF_FFFF, 32'd2);
    chk("t1_xfer", 32'(xfer_cnt), 32'd3);
    chk("t1_busy_fall", 32'(busy), 32'd0);

    // Round robin with four always-valid requesters, 1-beat packets
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) load(i, 8'(8'h40 + i*16 + k), 1'b1);
    drive();
    run_until(8, 40, "t2");
    step();
    ew = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h41, 8'h51, 8'h61, 8'h71};
    eg = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_wlog("t2", ew);
    chk_glog("t2", eg);
    ok = (wcyc.size() == 8);
    for (int k = 0; k + 1 < wcyc.size(); k++) if (wcyc[k+1] - wcyc[k] != 2) ok = 1'b0;
    chk("t2_one_winc_per_2", 32'(ok), 32'd1);
    chk("t2_xfer", 32'(xfer_cnt), 32'd8);

    // Burst cap: 6-beat packet split around a competing requester
    do_reset();
    for (int k = 1; k <= 6; k++) load(2, 8'(8'h60 + k), (k == 6));
    load(3, 8'h71, 1'b1);
    drive();
    run_until(7, 40, "t3");
    step();
    step();
    ew = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h71, 8'h65, 8'h66};
    eg = '{2, 3, 2};
    chk_wlog("t3", ew);
    chk_glog("t3", eg);
    chk("t3_xfer", 32'(xfer_cnt), 32'd7);

    // Backpressure after first beat
    do_reset();
    for (int k = 0; k < 4; k++) load(0, 8'(8'hA0 + k), (k == 3));
    drive();
    run_until(1, 10, "t4_first");
    fifo_wenable = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge wclk);
      #1;
      chk("t4_stall_winc", 32'(fifo_winc), 32'd0);
      chk("t4_stall_ready", 32'(req_ready), 32'd0);
      chk("t4_stall_grant", 32'(grant_id), 32'd0);
      chk("t4_stall_busy", 32'(busy), 32'd1);
      step();
    end
    fifo_wenable = 1'b1;
    run_until(4, 20, "t4");
    step();
    step();
    ew = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    chk_wlog("t4", ew);
    chk("t4_xfer", 32'(xfer_cnt), 32'd4);

    // Reset in the middle of a burst
    do_reset();
    for (int k = 0; k < 4; k++) load(1, 8'(8'hB0 + k), (k == 3));
    drive();
    run_until(2, 10, "t5_pre");
    wrst_n = 1'b0;
    #1;
    chk("t5_rst_winc", 32'(fifo_winc), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_xfer", 32'(xfer_cnt), 32'd0);
    chk("t5_rst_wdata", 32'(fifo_wdata), 32'd0);
    clear_all();
    drive();
    step();
    wrst_n = 1'b1;
    clear_all();
    load(0, 8'hC0, 1'b1);
    load(1, 8'hD0, 1'b1);
    drive();
    run_until(2, 10, "t5");
    step();
    ew = '{8'hC0, 8'hD0};
    eg = '{0, 1};
    chk_wlog("t5", ew);
    chk_glog("t5", eg);

    // Transfer counter wrap on the long-burst instance
    chk("t6_start_xfer", 32'(x2), 32'd0);
    v2 = 2'b01;
    for (int n = 1; n <= 66563; n++) begin
      @(posedge wclk);
      if (n == 2 || n == 65 || n == 66 || n == 66559 || n == 66563) begin
        @(negedge wclk);
        #1;
        case (n)
          2:       chk("t6_first", 32'(x2), 32'd1);
          65:      begin
                     chk("t6_burst64", 32'(x2), 32'd64);
                     chk("t6_gap_busy", 32'(busy2), 32'd0);
                   end
          66:      chk("t6_rearb_busy", 32'(busy2), 32'd1);
          66559:   chk("t6_max", 32'(x2), 32'hFFFF);
          default: chk("t6_wrapped", 32'(x2), 32'd2);
        endcase
      end
    end
    v2 = 2'b00;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter for the async FIFO, in the wclk domain. Up to NUM_REQ producers share the single FIFO write port (wdata/winc). Each producer uses a valid/ready handshake. The arbiter grants in bursts bounded by packet end or MAX_BURST, and honours FIFO backpressure through the FIFO's wenable (space-available) output.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width; matches FIFO wdata
MAX_BURST, 4, maximum beats per grant before forced re-arbitration (>=1)
ID_W, 2, grant index width = clog2(NUM_REQ)

Ports:
wclk  input  1  write-domain clock; all state on posedge
wrst_n  input  1  reset, asynchronous, active-low
req_valid  input  NUM_REQ  per-requester data valid
req_last  input  NUM_REQ  per-requester last beat of packet, qualified by req_valid
req_data  input  NUM_REQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid&ready at posedge
fifo_wenable  input  1  FIFO write enable / not-full (1 = FIFO can accept a write this cycle)
fifo_wdata  output  DATA_W  to FIFO wdata
fifo_winc  output  1  to FIFO winc
grant_id  output  ID_W  current/last granted requester
busy  output  1  1 while in BURST state
xfer_cnt  output  16  total beats written to FIFO since reset

Behaviour:
- Reset (wrst_n=0, async): state=IDLE, grant_id=0, last_gnt=NUM_REQ-1 so req 0 has first priority, beat_cnt=0, xfer_cnt=0. Outputs req_ready=0, fifo_winc=0, busy=0, fifo_wdata=0.
- Reset mid-burst: abort immediately. No winc is issued in the reset cycle. The partial packet is not resumed; the requester re-arbitrates after reset.
- States: IDLE and BURST.
- IDLE, some req_valid=1:
  - Select the first valid index scanning last_gnt+1, last_gnt+2, ... modulo NUM_REQ.
  - Register grant_id, clear beat_cnt, go to BURST.
  - Arbitration costs one cycle; no transfer happens in IDLE.
- IDLE, no req_valid: stay in IDLE.
- BURST, combinational outputs from registered state:
  - req_ready[grant_id] = fifo_wenable; all other req_ready = 0.
  - fifo_winc = req_valid[grant_id] & fifo_wenable.
  - fifo_wdata = req_data slice of grant_id when fifo_winc=1, else 0.
- Transfer (fifo_winc=1 at posedge): beat_cnt++, xfer_cnt++.
- Burst end: a transfer with req_last[grant_id]=1, or a transfer with beat_cnt==MAX_BURST-1.
  - Next state IDLE; last_gnt <= grant_id.
  - Minimum gap between bursts is one cycle.
- Forced end at MAX_BURST without last: the requester's packet continues in a later grant. Other requesters get service in between.
- FIFO full (fifo_wenable=0) in BURST: winc=0, ready=0, grant held, beat_cnt frozen. Resume on the first cycle wenable returns to 1, with no beat lost or duplicated.
- Granted requester drops valid mid-burst: grant held, no write, beat_cnt frozen. There is no preemption; requesters must complete packets.
- Other requesters asserting valid during BURST: ignored until the next IDLE.
- grant_id holds its value in IDLE (last grant); busy distinguishes live grants.
- xfer_cnt wraps 16'hFFFF -> 0 with no flag.
- Requester data must be stable while valid and not ready; the arbiter does not buffer data.

Test Plan:
- Reset then single requester: req0 sends 3 beats 0x11, 0x22, 0x33 (last on the third) with wenable=1. Required: one idle cycle, then winc=1 for 3 consecutive cycles with wdata 0x11/0x22/0x33, busy falls, xfer_cnt=3.
- Round-robin fairness: all 4 requesters continuously valid, 1-beat packets. Required: grant order 0,1,2,3,0,1, with one winc per 2 cycles.
- Burst cap: req2 sends a 6-beat packet (no last until beat 6) and req3 is valid. Required: req2 gets 4 beats, then req3 is granted, then req2 gets its remaining 2. xfer_cnt=6+req3 beats.
- Backpressure: wenable=0 for 5 cycles mid-burst after beat 1 of 0xA0..0xA3. Required: winc=0 and ready=0 during the stall, grant unchanged, FIFO receives exactly 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Reset mid-burst: assert wrst_n=0 after beat 2 of 4. Required: winc=0 immediately, state IDLE, xfer_cnt=0, req_ready=0, next grant goes to req0.
- Counter wrap: preload via 65536+2 single-beat writes. Required: xfer_cnt reads 2 after wrap.
